attack_sequencer: RTL
=====================

# attack_sequencer

Parametrised attack-animation sequencer for the battle screen. Draws a caster sprite layer once, then cycles through N−1 effect layers for a configurable number of rounds, holding each for a fixed frame time, and muxes the active layer's pixel stream onto the single VGA write port. Sits between the battle control FSM (start/done) and the per-sprite drawer modules (per-layer enable/done plus pixel buses).

## Interface
- NUM_LAYERS, 4: layer count. Layer 0 is the caster; layers 1..NUM_LAYERS−1 are effect frames. Legal range 1..8.
- NUM_CYCLES, 5: rounds through the effect layers. Legal range 1..15.
- FRAME_TICKS, 12500000: clock cycles each effect layer is held after its draw completes. Must be ≥1.
- X_W, 9 / Y_W, 8 / C_W, 3: pixel x, y and colour widths.
- ERASE_COLOUR, 0: colour forced during erase passes (see Configuration).
- clock  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  synchronous abort to IDLE; no done pulse is produced.
- layer_en  out  NUM_LAYERS  one-hot enable to the drawers.
- layer_done  in  NUM_LAYERS  per-layer draw-complete from the drawers.
- layer_plot  in  NUM_LAYERS  per-layer pixel-valid.
- layer_x  in  NUM_LAYERS*X_W  packed x; layer k is at [k*X_W +: X_W].
- layer_y  in  NUM_LAYERS*Y_W  packed y.
- layer_c  in  NUM_LAYERS*C_W  packed colour.
- out_x / out_y / out_colour / out_plot  out  X_W / Y_W / C_W / 1  muxed pixel stream.
- busy  out  1  high in any state except IDLE.
- done  out  1  single-cycle pulse when a sequence completes.

## Operation
- States: IDLE, DRAW, HOLD, ERASE (only with the macro), FINISH.
- Registers: layer index `idx`, which is $clog2(NUM_LAYERS) bits with a minimum of 1; round counter `rnd`, 4 bits; frame timer, inside frame_timer.
- IDLE: when start=1, go to DRAW with idx=0 and rnd=0.
- DRAW: layer_en = one-hot(idx). When layer_done[idx]=1 (accepted from the first DRAW cycle onward), take the next state as follows:
  - idx=0 and NUM_LAYERS=1: go to FINISH.
  - idx=0 otherwise: go to DRAW with idx=1. There is no hold for the caster.
  - idx≥1: go to HOLD and load the frame timer.
- HOLD: all enables low and out_plot=0. After FRAME_TICKS cycles, go to ERASE if the macro is defined; otherwise advance.
- Advance rule:
  - idx<NUM_LAYERS−1: idx+1, then DRAW.
  - idx=NUM_LAYERS−1 and rnd<NUM_CYCLES−1: rnd+1, idx=1, then DRAW.
  - otherwise: go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- Mux: in DRAW and ERASE, out_* equals layer[idx] and out_plot equals layer_plot[idx]. In every other state all out_* are 0.
- abort=1 in any non-IDLE state: next state is IDLE, enables drop on the next edge, and done stays 0. abort takes priority over layer_done and over timer expiry.
- start while busy: ignored.
- layer_done on a layer other than idx: ignored.

## Timing
- Reset values: state=IDLE, idx=0, rnd=0, timer=0, layer_en=0, all out_*=0, busy=0, done=0.
- All outputs are registered or decoded from registered state.
- start=1 at edge t makes layer_en[0]=1 and busy=1 from t+1.
- layer_done sampled at an edge drops layer_en at the next edge.
- HOLD lasts exactly FRAME_TICKS cycles.
- done rises one cycle after the final HOLD (or ERASE) exit and lasts one cycle. busy falls in the same cycle done falls.
- Pixel mux is combinational from idx and the state decode; there is zero added latency on the pixel path.

## Configuration
- Macro: ATTACK_SEQ_ERASE_EN.
- Defined: after each HOLD, enter ERASE. ERASE re-asserts layer_en[idx], passes x/y/plot through, and forces out_colour=ERASE_COLOUR. On layer_done[idx] it advances per the advance rule. The caster layer is never erased.
- Undefined: the ERASE state, its logic and the ERASE_COLOUR usage are not compiled. HOLD advances directly.

## Structure
- attack_seq_pkg holds:
  - the state enum: IDLE, DRAW, HOLD, ERASE, FINISH;
  - default width constants: X_W, Y_W, C_W;
  - MAX_LAYERS=8 and MAX_CYCLES=15.
- Sub-module frame_timer (parameter FRAME_TICKS; ports clock, reset, load, expired): a down-counter reloaded on load that pulses expired when it reaches 0.

## Test plan
Unless stated, NUM_LAYERS=4, NUM_CYCLES=2, FRAME_TICKS=3, and drawers model layer_done 5 cycles after the enable rises.
- Basic run, no macro: start pulse gives layer_en order 0001, 0010, 0100, 1000, 0010, 0100, 1000. Each effect layer is followed by exactly 3 idle cycles. done pulses exactly once, and busy is low the cycle after done.
- Mux: layer 2 drives x=188, y=40, c=5, plot=1 during its DRAW, and other layers drive garbage. Outputs show 188/40/5/1 only while layer_en=0100, and 0 in HOLD.
- Abort: abort=1 on the 3rd HOLD cycle of round 1. Next cycle is IDLE, layer_en=0, done never pulses, and a new start restarts from layer 0.
- Reset mid-op: reset=0 asynchronously during DRAW of layer 3. All outputs are 0 immediately, with no clock edge needed.
- Edge parameters: NUM_LAYERS=1 gives a single draw of layer 0, then done. Start held high continuously during a run does not restart it.
- With ATTACK_SEQ_ERASE_EN and ERASE_COLOUR=0: each effect layer is drawn, held 3 cycles, then redrawn with out_colour=0. Layer 0 is never redrawn. Total effect enable assertions = 12.

Source files
------------

// File: rtl/attack_seq_pkg.sv
// attack_seq_pkg: shared state encoding and default widths for the attack sequencer.
package attack_seq_pkg;

    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int C_W        = 3;
    localparam int MAX_LAYERS = 8;
    localparam int MAX_CYCLES = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAW   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_ERASE  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    // Index width for a layer count; a single layer still needs one bit.
    function automatic int idx_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

endpackage

// File: rtl/attack_sequencer_frame_timer.sv
// frame_timer: down-counter that holds an effect layer on screen.
// A load restarts the count; expired is high during the last held cycle,
// so the owner leaves its hold state exactly FRAME_TICKS cycles after the load.
module frame_timer #(
    parameter int FRAME_TICKS = 12500000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] count_r;
    logic             running_r;

    // Reload on load, otherwise count down to zero and stop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r   <= {CNT_W{1'b0}};
            running_r <= 1'b0;
        end else if (load) begin
            count_r   <= RELOAD;
            running_r <= 1'b1;
        end else if (running_r) begin
            if (count_r == {CNT_W{1'b0}}) begin
                running_r <= 1'b0;
            end else begin
                count_r <= count_r - CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = running_r && (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/attack_sequencer.sv
// attack_sequencer: draws the caster layer once, then cycles the effect layers
// for NUM_CYCLES rounds, holding each for FRAME_TICKS, and muxes the active
// layer's pixel stream onto the single VGA write port.
// Optional feature macro: ATTACK_SEQ_ERASE_EN (redraw each effect layer in
// ERASE_COLOUR after its hold).
module attack_sequencer
    import attack_seq_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int NUM_CYCLES  = 5,
    parameter int FRAME_TICKS = 12500000,
    parameter int X_W         = attack_seq_pkg::X_W,
    parameter int Y_W         = attack_seq_pkg::Y_W,
    parameter int C_W         = attack_seq_pkg::C_W
`ifdef ATTACK_SEQ_ERASE_EN
    ,
    parameter logic [C_W-1:0] ERASE_COLOUR = {C_W{1'b0}}
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    output logic [NUM_LAYERS-1:0]     layer_en,
    input  logic [NUM_LAYERS-1:0]     layer_done,
    input  logic [NUM_LAYERS-1:0]     layer_plot,
    input  logic [NUM_LAYERS*X_W-1:0] layer_x,
    input  logic [NUM_LAYERS*Y_W-1:0] layer_y,
    input  logic [NUM_LAYERS*C_W-1:0] layer_c,
    output logic [X_W-1:0]            out_x,
    output logic [Y_W-1:0]            out_y,
    output logic [C_W-1:0]            out_colour,
    output logic                      out_plot,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = idx_width(NUM_LAYERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [3:0]       LAST_RND = 4'(NUM_CYCLES - 1);

    seq_state_e              state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [3:0]              rnd_r;
    logic [NUM_LAYERS-1:0]   layer_en_r;
    logic                    busy_r;
    logic                    done_r;

    logic                    done_sel_s;
    logic                    plot_sel_s;
    logic [X_W-1:0]          x_sel_s;
    logic [Y_W-1:0]          y_sel_s;
    logic [C_W-1:0]          c_sel_s;
    logic [X_W-1:0]          out_x_s;
    logic [Y_W-1:0]          out_y_s;
    logic [C_W-1:0]          out_c_s;
    logic                    out_plot_s;
    seq_state_e              adv_state_s;
    logic [IDX_W-1:0]        adv_idx_s;
    logic [3:0]              adv_rnd_s;
    logic                    adv_done_s;
    logic                    timer_load_s;
    logic                    timer_expired_s;

    // One-hot enable vector for a layer index.
    function automatic logic [NUM_LAYERS-1:0] onehot_f(input logic [IDX_W-1:0] i);
        logic [NUM_LAYERS-1:0] v;
        v = {NUM_LAYERS{1'b0}};
        for (int k = 0; k < NUM_LAYERS; k++) begin
            v[k] = (i == IDX_W'(k));
        end
        return v;
    endfunction

    // Select the active layer's done flag and pixel bus by idx.
    always_comb begin
        done_sel_s = 1'b0;
        plot_sel_s = 1'b0;
        x_sel_s    = {X_W{1'b0}};
        y_sel_s    = {Y_W{1'b0}};
        c_sel_s    = {C_W{1'b0}};
        for (int k = 0; k < NUM_LAYERS; k++) begin
            done_sel_s = done_sel_s | (layer_done[k] & (idx_r == IDX_W'(k)));
            plot_sel_s = plot_sel_s | (layer_plot[k] & (idx_r == IDX_W'(k)));
            x_sel_s    = x_sel_s | (layer_x[k*X_W +: X_W] & {X_W{idx_r == IDX_W'(k)}});
            y_sel_s    = y_sel_s | (layer_y[k*Y_W +: Y_W] & {Y_W{idx_r == IDX_W'(k)}});
            c_sel_s    = c_sel_s | (layer_c[k*C_W +: C_W] & {C_W{idx_r == IDX_W'(k)}});
        end
    end

    // Where the sequence goes once an effect layer is finished with.
    always_comb begin
        adv_state_s = ST_DRAW;
        adv_idx_s   = idx_r;
        adv_rnd_s   = rnd_r;
        adv_done_s  = 1'b0;
        if (idx_r < LAST_IDX) begin
            adv_idx_s = idx_r + IDX_ONE;
        end else if (rnd_r < LAST_RND) begin
            adv_rnd_s = rnd_r + 4'd1;
            adv_idx_s = IDX_ONE;
        end else begin
            adv_state_s = ST_FINISH;
            adv_done_s  = 1'b1;
        end
    end

    // Pixel port follows the selected layer only while it is being drawn.
    always_comb begin
        out_x_s    = {X_W{1'b0}};
        out_y_s    = {Y_W{1'b0}};
        out_c_s    = {C_W{1'b0}};
        out_plot_s = 1'b0;
        if (state_r == ST_DRAW) begin
            out_x_s    = x_sel_s;
            out_y_s    = y_sel_s;
            out_c_s    = c_sel_s;
            out_plot_s = plot_sel_s;
        end
`ifdef ATTACK_SEQ_ERASE_EN
        else if (state_r == ST_ERASE) begin
            out_x_s    = x_sel_s;
            out_y_s    = y_sel_s;
            out_c_s    = ERASE_COLOUR;
            out_plot_s = plot_sel_s;
        end
`endif
        else begin
            out_x_s    = {X_W{1'b0}};
            out_y_s    = {Y_W{1'b0}};
            out_c_s    = {C_W{1'b0}};
            out_plot_s = 1'b0;
        end
    end

    assign timer_load_s = (state_r == ST_DRAW) && done_sel_s && (idx_r != IDX_ZERO) && !abort;

    frame_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_frame_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (timer_load_s),
        .expired (timer_expired_s)
    );

    // Sequencer FSM with registered enables, busy and done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_ZERO;
            rnd_r      <= 4'd0;
            layer_en_r <= {NUM_LAYERS{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_ZERO;
            rnd_r      <= 4'd0;
            layer_en_r <= {NUM_LAYERS{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_DRAW;
                        idx_r      <= IDX_ZERO;
                        rnd_r      <= 4'd0;
                        layer_en_r <= onehot_f(IDX_ZERO);
                        busy_r     <= 1'b1;
                    end else begin
                        layer_en_r <= {NUM_LAYERS{1'b0}};
                        busy_r     <= 1'b0;
                    end
                end
                ST_DRAW: begin
                    if (done_sel_s) begin
                        if (idx_r != IDX_ZERO) begin
                            state_r    <= ST_HOLD;
                            layer_en_r <= {NUM_LAYERS{1'b0}};
                        end else if (NUM_LAYERS == 1) begin
                            state_r    <= ST_FINISH;
                            layer_en_r <= {NUM_LAYERS{1'b0}};
                            done_r     <= 1'b1;
                        end else begin
                            idx_r      <= IDX_ONE;
                            layer_en_r <= onehot_f(IDX_ONE);
                        end
                    end else begin
                        state_r <= ST_DRAW;
                    end
                end
                ST_HOLD: begin
                    if (timer_expired_s) begin
`ifdef ATTACK_SEQ_ERASE_EN
                        state_r    <= ST_ERASE;
                        layer_en_r <= onehot_f(idx_r);
`else
                        state_r    <= adv_state_s;
                        idx_r      <= adv_idx_s;
                        rnd_r      <= adv_rnd_s;
                        done_r     <= adv_done_s;
                        layer_en_r <= (adv_state_s == ST_DRAW) ? onehot_f(adv_idx_s)
                                                               : {NUM_LAYERS{1'b0}};
`endif
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
`ifdef ATTACK_SEQ_ERASE_EN
                ST_ERASE: begin
                    if (done_sel_s) begin
                        state_r    <= adv_state_s;
                        idx_r      <= adv_idx_s;
                        rnd_r      <= adv_rnd_s;
                        done_r     <= adv_done_s;
                        layer_en_r <= (adv_state_s == ST_DRAW) ? onehot_f(adv_idx_s)
                                                               : {NUM_LAYERS{1'b0}};
                    end else begin
                        state_r <= ST_ERASE;
                    end
                end
`endif
                ST_FINISH: begin
                    state_r    <= ST_IDLE;
                    idx_r      <= IDX_ZERO;
                    rnd_r      <= 4'd0;
                    layer_en_r <= {NUM_LAYERS{1'b0}};
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    idx_r      <= IDX_ZERO;
                    rnd_r      <= 4'd0;
                    layer_en_r <= {NUM_LAYERS{1'b0}};
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign layer_en   = layer_en_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign out_x      = out_x_s;
    assign out_y      = out_y_s;
    assign out_colour = out_c_s;
    assign out_plot   = out_plot_s;

endmodule
